// File: rtl/stack_arbiter_if.sv
// Bundle of requester A/B handshakes, stack command/response lines and status
// shared between the stack arbiter (slave) and its environment (master).
interface stack_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              a_req;
    logic              a_op;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_op;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              stk_reset;
    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_data_in;
    logic [DATA_W-1:0] stk_data_out;
    logic              stk_error;

    logic [CNT_W-1:0]  count;
    logic              busy;

    modport slave (
        input  a_req, a_op, a_wdata, b_req, b_op, b_wdata, stk_data_out, stk_error,
        output a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
        output stk_reset, stk_push, stk_pop, stk_data_in, count, busy
    );

    modport master (
        output a_req, a_op, a_wdata, b_req, b_op, b_wdata, stk_data_out, stk_error,
        input  a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
        input  stk_reset, stk_push, stk_pop, stk_data_in, count, busy
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter giving two requesters serialized push/pop access to one
// stack; tracks occupancy and rejects overflow/underflow before touching the stack.
module stack_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic            clk,
    input logic            reset,
    stack_arbiter_if.slave io_bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    logic              r_last_b;
    logic              r_gnt_b;
    logic              r_op;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_a_err;
    logic              r_b_err;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_push;
    logic              r_pop;
    logic [DATA_W-1:0] r_data_in;
    logic [CNT_W-1:0]  r_count;
    logic              r_stk_reset;

    logic              w_any_req;
    logic              w_gnt_b;
    logic              w_op;
    logic [DATA_W-1:0] w_wdata;
    logic              w_reject;

    // B wins only when A is idle or A was the last one served.
    assign w_any_req = io_bus.a_req | io_bus.b_req;
    assign w_gnt_b   = io_bus.b_req & (~io_bus.a_req | ~r_last_b);
    assign w_op      = w_gnt_b ? io_bus.b_op    : io_bus.a_op;
    assign w_wdata   = w_gnt_b ? io_bus.b_wdata : io_bus.a_wdata;
    assign w_reject  = w_op ? (r_count == FULL_CNT) : (r_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last_b    <= 1'b1;
            r_gnt_b     <= 1'b0;
            r_op        <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_data_in   <= '0;
            r_count     <= '0;
            r_stk_reset <= 1'b1;
        end else begin
            r_stk_reset <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_data_in   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_b  <= w_gnt_b;
                        r_last_b <= w_gnt_b;
                        r_op     <= w_op;
                        if (w_reject) begin
                            r_state <= RESP;
                            r_a_ack <= ~w_gnt_b;
                            r_b_ack <= w_gnt_b;
                            r_a_err <= ~w_gnt_b;
                            r_b_err <= w_gnt_b;
                        end else begin
                            r_state   <= ISSUE;
                            r_push    <= w_op;
                            r_pop     <= ~w_op;
                            r_data_in <= w_op ? w_wdata : '0;
                        end
                    end
                end
                ISSUE: begin
                    r_count <= r_op ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // The stack's top-of-stack and error are valid one cycle after the strobe.
                    r_state   <= RESP;
                    r_a_ack   <= ~r_gnt_b;
                    r_b_ack   <= r_gnt_b;
                    r_a_err   <= ~r_gnt_b & io_bus.stk_error;
                    r_b_err   <= r_gnt_b & io_bus.stk_error;
                    r_a_rdata <= (~r_gnt_b & ~r_op) ? io_bus.stk_data_out : '0;
                    r_b_rdata <= (r_gnt_b & ~r_op) ? io_bus.stk_data_out : '0;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.a_ack       = r_a_ack;
    assign io_bus.a_err       = r_a_err;
    assign io_bus.a_rdata     = r_a_rdata;
    assign io_bus.b_ack       = r_b_ack;
    assign io_bus.b_err       = r_b_err;
    assign io_bus.b_rdata     = r_b_rdata;
    assign io_bus.stk_reset   = r_stk_reset;
    assign io_bus.stk_push    = r_push;
    assign io_bus.stk_pop     = r_pop;
    assign io_bus.stk_data_in = r_data_in;
    assign io_bus.count       = r_count;
    assign io_bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural stack model, table of requester
// transactions checked through an expected-response queue, plus reset cases.
module tb_stack_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_arbiter_if #(.DATA_W(8), .DEPTH(16)) bus ();

    stack_arbiter #(.DATA_W(8), .DEPTH(16)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .io_bus (bus)
    );

    // Behavioural stack: top-of-stack output registered on each command.
    logic [7:0] stk_mem [0:15];
    int         sp;
    logic [7:0] s_dout;
    logic       s_err;
    bit         inject_err;

    assign bus.stk_data_out = s_dout;
    assign bus.stk_error    = s_err | inject_err;

    always @(posedge clk) begin
        if (bus.stk_reset) begin
            sp     <= 0;
            s_dout <= 8'h00;
            s_err  <= 1'b0;
        end else if (bus.stk_push) begin
            if (sp == 16) s_err <= 1'b1;
            else begin
                stk_mem[sp] <= bus.stk_data_in;
                sp          <= sp + 1;
                s_dout      <= bus.stk_data_in;
                s_err       <= 1'b0;
            end
        end else if (bus.stk_pop) begin
            if (sp == 0) s_err <= 1'b1;
            else begin
                s_dout <= stk_mem[sp-1];
                sp     <= sp - 1;
                s_err  <= 1'b0;
            end
        end
    end

    int cyc = 0;
    int n_push = 0;
    int n_pop = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.stk_push) n_push <= n_push + 1;
        if (bus.stk_pop)  n_pop  <= n_pop + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        bit         is_b;
        logic [7:0] rd;
        bit         err;
        int         lat;
    } exp_t;

    typedef struct {
        bit a_en; bit a_op; logic [7:0] a_wd;
        bit b_en; bit b_op; logic [7:0] b_wd;
        bit r1_b; logic [7:0] r1_rd; bit r1_err; int r1_lat;
        bit has2; logic [7:0] r2_rd; bit r2_err; int r2_lat;
        int pushes; int pops; int cnt; bit inj;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic vec_t mk(input int a_en, input int a_op, input int a_wd,
                                input int b_en, input int b_op, input int b_wd,
                                input int r1_b, input int r1_rd, input int r1_err, input int r1_lat,
                                input int has2, input int r2_rd, input int r2_err, input int r2_lat,
                                input int pushes, input int pops, input int cnt, input int inj);
        vec_t v;
        v.a_en = bit'(a_en); v.a_op = bit'(a_op); v.a_wd = 8'(a_wd);
        v.b_en = bit'(b_en); v.b_op = bit'(b_op); v.b_wd = 8'(b_wd);
        v.r1_b = bit'(r1_b); v.r1_rd = 8'(r1_rd); v.r1_err = bit'(r1_err); v.r1_lat = r1_lat;
        v.has2 = bit'(has2); v.r2_rd = 8'(r2_rd); v.r2_err = bit'(r2_err); v.r2_lat = r2_lat;
        v.pushes = pushes; v.pops = pops; v.cnt = cnt; v.inj = bit'(inj);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   t0;
        int   p0;
        int   q0;
        bit   got_b;
        p0 = n_push;
        q0 = n_pop;
        e.is_b = v.r1_b; e.rd = v.r1_rd; e.err = v.r1_err; e.lat = v.r1_lat;
        sb.push_back(e);
        if (v.has2) begin
            e.is_b = ~v.r1_b; e.rd = v.r2_rd; e.err = v.r2_err; e.lat = v.r2_lat;
            sb.push_back(e);
        end
        inject_err = v.inj;
        @(posedge clk); #1;
        bus.a_req = v.a_en; bus.a_op = v.a_op; bus.a_wdata = v.a_wd;
        bus.b_req = v.b_en; bus.b_op = v.b_op; bus.b_wdata = v.b_wd;
        t0 = cyc;
        for (int k = 0; k < 30 && sb.size() > 0; k++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) begin
                got_b = bus.b_ack;
                e = sb.pop_front();
                check($sformatf("v%0d_ack_owner", idx), got_b, e.is_b);
                check($sformatf("v%0d_latency", idx), cyc - t0, e.lat);
                if (got_b) begin
                    check($sformatf("v%0d_b_rdata", idx), bus.b_rdata, e.rd);
                    check($sformatf("v%0d_b_err", idx), bus.b_err, e.err);
                    check($sformatf("v%0d_a_idle", idx), {bus.a_ack, bus.a_rdata, bus.a_err}, 0);
                    bus.b_req = 1'b0;
                end else begin
                    check($sformatf("v%0d_a_rdata", idx), bus.a_rdata, e.rd);
                    check($sformatf("v%0d_a_err", idx), bus.a_err, e.err);
                    check($sformatf("v%0d_b_idle", idx), {bus.b_ack, bus.b_rdata, bus.b_err}, 0);
                    bus.a_req = 1'b0;
                end
            end
        end
        if (sb.size() != 0) begin
            check($sformatf("v%0d_ack_timeout", idx), sb.size(), 0);
            sb.delete();
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        inject_err = 1'b0;
        check($sformatf("v%0d_count", idx), bus.count, v.cnt);
        check($sformatf("v%0d_busy", idx), bus.busy, 0);
        check($sformatf("v%0d_push_pulses", idx), n_push - p0, v.pushes);
        check($sformatf("v%0d_pop_pulses", idx), n_pop - q0, v.pops);
        $display("txn %0d: a_en=%0d a_op=%0d b_en=%0d b_op=%0d count=%0d", idx, v.a_en, v.a_op, v.b_en, v.b_op, bus.count);
    endtask

    initial begin
        int acks;
        inject_err = 1'b0;
        bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_wdata = 8'h00;
        bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_wdata = 8'h00;

        // Build the transaction table.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1,1,i, 0,0,0, 0,0,0,3, 0,0,0,0, 1,0,i+1,0));
        vecs.push_back(mk(0,0,0, 1,1,8'hAA, 1,0,1,1, 0,0,0,0, 0,0,16,0));
        vecs.push_back(mk(1,0,0, 1,0,0, 0,8'h0F,0,3, 1,8'h0E,0,7, 0,2,14,0));
        vecs.push_back(mk(1,0,0, 1,0,0, 0,8'h0D,0,3, 1,8'h0C,0,7, 0,2,12,0));
        vecs.push_back(mk(1,1,8'h55, 1,0,0, 0,0,0,3, 1,8'h55,0,7, 1,1,12,0));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(1,0,0, 0,0,0, 0,8'h0B-i,0,3, 0,0,0,0, 0,1,11-i,0));
        vecs.push_back(mk(1,0,0, 0,0,0, 0,0,1,1, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0, 1,1,8'h3C, 1,0,0,3, 1,8'h3C,0,7, 1,1,0,0));
        vecs.push_back(mk(1,1,8'h99, 0,0,0, 0,0,1,3, 0,0,0,0, 1,0,1,1));
        vecs.push_back(mk(1,0,0, 0,0,0, 0,8'h99,0,3, 0,0,0,0, 0,1,0,0));

        // Reset held: everything quiet, stack reset asserted.
        repeat (2) @(negedge clk);
        check("rst_outputs", {bus.a_ack, bus.a_rdata, bus.a_err, bus.b_ack, bus.b_rdata, bus.b_err,
                              bus.stk_push, bus.stk_pop, bus.stk_data_in, bus.count, bus.busy}, 0);
        check("rst_stk_reset_held", bus.stk_reset, 1);
        rst_n = 1'b1;
        #1;
        check("rst_stk_reset_before_edge", bus.stk_reset, 1);
        @(posedge clk); #1;
        check("rst_stk_reset_after_edge", bus.stk_reset, 0);
        check("rst_count", bus.count, 0);
        $display("txn reset: stk_reset=%0d count=%0d", bus.stk_reset, bus.count);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted while the arbiter sits in WAIT.
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_op = 1'b1; bus.a_wdata = 8'h77;
        @(posedge clk);
        @(posedge clk); #2;
        check("wait_busy", bus.busy, 1);
        check("wait_count", bus.count, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_count", bus.count, 0);
        check("abort_stk_reset", bus.stk_reset, 1);
        bus.a_req = 1'b0;
        acks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) acks++;
        end
        check("abort_no_ack", acks, 0);
        check("abort_idle", {bus.busy, bus.count, bus.stk_reset}, 0);
        $display("txn abort: acks=%0d count=%0d busy=%0d", acks, bus.count, bus.busy);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
